// File: rtl/sr_ff_bank.sv
// Bank of independent clocked set/reset flip-flops with programmable S=R=1 handling,
// registered rise/fall pulses, sticky illegal-command flags and a saturating illegal-cycle count.
module sr_ff_bank #(
  parameter int               WIDTH          = 8,
  parameter int               ILLEGAL_POLICY = 0,
  parameter logic [WIDTH-1:0] RESET_VAL      = '0,
  parameter int               CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [2*WIDTH-1:0] sr,
  input  logic               err_clr,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   q_rise,
  output logic [WIDTH-1:0]   q_fall,
  output logic [WIDTH-1:0]   illegal,
  output logic [CNT_W-1:0]   illegal_cnt
);

  localparam int POL_SET    = 1;
  localparam int POL_RESET  = 2;
  localparam int POL_TOGGLE = 3;

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] ill_vec;
  logic             any_ill;

  function automatic logic resolve(input logic s, input logic r, input logic cur);
    logic nxt;
    nxt = cur;
    unique case ({s, r})
      2'b00: nxt = cur;
      2'b01: nxt = 1'b0;
      2'b10: nxt = 1'b1;
      default: begin
        // S=R=1: anything other than the three defined policies holds.
        if (ILLEGAL_POLICY == POL_SET)         nxt = 1'b1;
        else if (ILLEGAL_POLICY == POL_RESET)  nxt = 1'b0;
        else if (ILLEGAL_POLICY == POL_TOGGLE) nxt = ~cur;
        else                                   nxt = cur;
      end
    endcase
    return nxt;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    q_next  = q;
    ill_vec = '0;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        q_next[i]  = resolve(sr[2*i+1], sr[2*i], q[i]);
        ill_vec[i] = sr[2*i+1] & sr[2*i];
      end
    end
  end

  assign any_ill = |ill_vec;

  // Register stage: q, edge pulses and error state all update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= RESET_VAL;
      q_rise      <= '0;
      q_fall      <= '0;
      illegal     <= '0;
      illegal_cnt <= '0;
    end else begin
      q      <= q_next;
      q_rise <= q_next & ~q;
      q_fall <= ~q_next & q;
      // A fresh illegal command wins over a simultaneous clear.
      illegal <= err_clr ? ill_vec : (illegal | ill_vec);
      if (err_clr)
        illegal_cnt <= any_ill ? CNT_W'(1) : '0;
      else if (any_ill)
        illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: five instances sharing stimulus, covering all S=R=1
// policies, a non-zero reset value and a narrow saturating counter.
module tb_sr_ff_bank;
  logic        clk = 1'b0;
  logic        rst, en, err_clr;
  logic [15:0] sr;

  logic [7:0] q0, r0, f0, i0, c0;
  logic [7:0] q1, r1, f1, i1, c1;
  logic [7:0] q2, r2, f2, i2, c2;
  logic [7:0] q3, r3, f3, i3, c3;
  logic [7:0] q4, r4, f4, i4;
  logic [1:0] c4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(0), .RESET_VAL(8'hA5), .CNT_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .sr(sr), .err_clr(err_clr),
    .q(q0), .q_rise(r0), .q_fall(f0), .illegal(i0), .illegal_cnt(c0));
  sr_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(1), .RESET_VAL(8'h00), .CNT_W(8)) u1 (
    .clk(clk), .rst(rst), .en(en), .sr(sr), .err_clr(err_clr),
    .q(q1), .q_rise(r1), .q_fall(f1), .illegal(i1), .illegal_cnt(c1));
  sr_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(2), .RESET_VAL(8'h00), .CNT_W(8)) u2 (
    .clk(clk), .rst(rst), .en(en), .sr(sr), .err_clr(err_clr),
    .q(q2), .q_rise(r2), .q_fall(f2), .illegal(i2), .illegal_cnt(c2));
  sr_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(3), .RESET_VAL(8'h00), .CNT_W(8)) u3 (
    .clk(clk), .rst(rst), .en(en), .sr(sr), .err_clr(err_clr),
    .q(q3), .q_rise(r3), .q_fall(f3), .illegal(i3), .illegal_cnt(c3));
  sr_ff_bank #(.WIDTH(8), .ILLEGAL_POLICY(1), .RESET_VAL(8'h00), .CNT_W(2)) u4 (
    .clk(clk), .rst(rst), .en(en), .sr(sr), .err_clr(err_clr),
    .q(q4), .q_rise(r4), .q_fall(f4), .illegal(i4), .illegal_cnt(c4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sr = '0; err_clr = 1'b0;
    step();
    check("rst_q0", q0, 8'hA5);
    check("rst_q1", q1, 8'h00);
    check("rst_rise0", r0, 8'h00);
    check("rst_ill0", i0, 8'h00);
    check("rst_cnt0", c0, 8'h00);
    rst = 1'b0;

    // set all, then reset all
    en = 1'b1; sr = 16'hAAAA;
    step();
    check("set_q1", q1, 8'hFF);
    check("set_rise1", r1, 8'hFF);
    check("set_rise0", r0, 8'h5A);
    check("set_fall1", f1, 8'h00);
    sr = 16'h5555;
    step();
    check("clr_q1", q1, 8'h00);
    check("clr_fall1", f1, 8'hFF);
    check("clr_rise1", r1, 8'h00);
    sr = 16'h0000;
    step();
    check("hold_fall1", f1, 8'h00);
    check("hold_q0", q0, 8'h00);

    // S=R=1 for three cycles under each policy
    sr = 16'hFFFF;
    step();
    check("p3_c1_q", q3, 8'hFF);
    check("p3_c1_rise", r3, 8'hFF);
    step();
    check("p3_c2_q", q3, 8'h00);
    check("p3_c2_fall", f3, 8'hFF);
    step();
    check("p3_c3_q", q3, 8'hFF);
    check("p3_c3_rise", r3, 8'hFF);
    check("p0_q", q0, 8'h00);
    check("p1_q", q1, 8'hFF);
    check("p2_q", q2, 8'h00);
    check("p0_ill", i0, 8'hFF);
    check("p0_cnt", c0, 8'd3);

    // global enable low
    en = 1'b0; sr = 16'hAAAA;
    step();
    check("en0_q2", q2, 8'h00);
    check("en0_rise2", r2, 8'h00);
    check("en0_rise3", r3, 8'h00);
    sr = 16'hFFFF;
    step();
    check("en0_q3", q3, 8'hFF);
    check("en0_cnt0", c0, 8'd3);
    check("en0_ill2", i2, 8'hFF);
    en = 1'b1; sr = 16'h5555;
    step();
    check("en1_q3", q3, 8'h00);
    check("en1_fall3", f3, 8'hFF);

    // saturation and clear interplay
    err_clr = 1'b1; sr = 16'h0000;
    step();
    check("clr_cnt4", c4, 2'd0);
    check("clr_ill0", i0, 8'h00);
    err_clr = 1'b0; sr = 16'hFFFF;
    repeat (5) step();
    check("sat_cnt4", c4, 2'd3);
    check("cnt0_5", c0, 8'd5);
    err_clr = 1'b1; sr = 16'h0003;
    step();
    check("clr_ill_cnt4", c4, 2'd1);
    check("clr_ill_cnt0", c0, 8'd1);
    check("clr_ill_ill0", i0, 8'h01);
    sr = 16'h0000;
    step();
    check("clr_only_cnt4", c4, 2'd0);
    check("clr_only_ill0", i0, 8'h00);
    err_clr = 1'b0;

    // channel independence from q=06, policy 1
    sr = 16'h5569;
    step();
    check("ind_pre_q1", q1, 8'h06);
    sr = 16'h0036;
    step();
    check("ind_q1", q1, 8'h05);
    check("ind_ill1", i1, 8'h04);
    check("ind_rise1", r1, 8'h01);
    check("ind_fall1", f1, 8'h02);
    check("ind_cnt1", c1, 8'd1);

    // asynchronous reset mid-cycle
    sr = 16'hAAAA;
    step();
    check("pre_rst_q0", q0, 8'hFF);
    #2 rst = 1'b1;
    #1;
    check("async_q0", q0, 8'hA5);
    check("async_ill1", i1, 8'h00);
    check("async_cnt1", c1, 8'd0);
    check("async_rise0", r0, 8'h00);
    #1 rst = 1'b0;
    step();
    check("post_rst_q0", q0, 8'hFF);
    check("post_rst_rise0", r0, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
